// File: rtl/ysyx_25060170_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25060170_dmem_slave
// Purpose  : Single-outstanding 64-bit data-memory responder for the LSU, with
//            byte-strobed stores, full-word loads and a fixed request latency.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25060170_dmem_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int          c_IDX_W     = $clog2(DEPTH);
    localparam logic [28:0] c_BASE_WORD = BASE_ADDR[31:3];
    localparam logic [28:0] c_DEPTH_W   = 29'(DEPTH);
    localparam logic [3:0]  c_LAT_M1    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;

    logic                r_we;
    logic [28:0]         r_word;
    logic [63:0]         r_wdata;
    logic [7:0]          r_wstrb;
    logic [63:0]         r_rdata;
    logic                r_err;
    logic [63:0]         r_mem [DEPTH];

    logic                w_accept;
    logic                w_hit;
    logic [28:0]         w_off;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_unused_addr;

    assign req_ready  = (r_state == S_IDLE) && rst;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign w_accept   = req_valid && req_ready;

    // Word-granular compare: addresses below BASE fail the >= test instead of
    // wrapping into range through the subtraction.
    assign w_off = r_word - c_BASE_WORD;
    assign w_hit = (r_word >= c_BASE_WORD) && (w_off < c_DEPTH_W);
    assign w_idx = w_off[c_IDX_W-1:0];

    assign w_unused_addr = ^req_addr[2:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The ACCESS cycle is counted inside LATENCY, so WAIT lasts LATENCY-1 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = c_LAT_M1;
                    w_state_nxt = (LATENCY == 1) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_word  <= 29'd0;
            r_wdata <= 64'd0;
            r_wstrb <= 8'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_word  <= req_addr[31:3];
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
            end
            if (r_state == S_ACCESS) begin
                r_err   <= ~w_hit;
                r_rdata <= (w_hit && !r_we) ? r_mem[w_idx] : 64'd0;
            end
        end
    end

    // Array is deliberately unreset; reset forces IDLE asynchronously, which
    // suppresses any write whose ACCESS edge has not yet happened.
    always_ff @(posedge clk) begin
        if ((r_state == S_ACCESS) && r_we && w_hit) begin
            for (int i = 0; i < 8; i++) begin
                if (r_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060170_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25060170_dmem_slave
// Purpose  : Directed self-checking bench for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25060170_dmem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_ready;

    logic        req_valid0, req_ready0, resp_valid0, resp_err0;
    logic [63:0] resp_rdata0;
    logic        req_valid1, req_ready1, resp_valid1, resp_err1;
    logic [63:0] resp_rdata1;

    int          n_vec = 0;
    int          n_err = 0;

    logic [63:0] rd;
    logic        er;
    int          lat;

    always #5 clk = ~clk;

    ysyx_25060170_dmem_slave #(
        .BASE_ADDR (32'h8000_0000),
        .DEPTH     (1024),
        .LATENCY   (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid0),
        .req_ready  (req_ready0),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid0),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata0),
        .resp_err   (resp_err0)
    );

    ysyx_25060170_dmem_slave #(
        .BASE_ADDR (32'h8000_0000),
        .DEPTH     (1024),
        .LATENCY   (1)
    ) u_dut_l1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid1),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata1),
        .resp_err   (resp_err1)
    );

    // Entered and left #1 after a rising edge; lat counts edges from accept to resp_valid.
    task automatic txn(input bit which, input bit we, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [7:0] ws,
                       output logic [63:0] o_rd, output logic o_er, output int o_lat);
        int n;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_wstrb  = ws;
        resp_ready = 1'b1;
        if (which) req_valid1 = 1'b1;
        else       req_valid0 = 1'b1;
        n = 0;
        while (!(which ? req_ready1 : req_ready0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        o_lat = 0;
        while (!(which ? resp_valid1 : resp_valid0) && o_lat < 20) begin
            @(posedge clk); #1;
            o_lat++;
        end
        o_rd = which ? resp_rdata1 : resp_rdata0;
        o_er = which ? resp_err1   : resp_err0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0; req_we = 1'b0;
        req_addr = 32'd0; req_wdata = 64'd0; req_wstrb = 8'd0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (resp_valid0 !== 1'b0) begin n_err++; $error("FAIL rst_resp_valid: observed %0h", resp_valid0); end
        n_vec++; if (resp_rdata0 !== 64'd0) begin n_err++; $error("FAIL rst_resp_rdata: observed %0h", resp_rdata0); end
        n_vec++; if (resp_err0 !== 1'b0) begin n_err++; $error("FAIL rst_resp_err: observed %0h", resp_err0); end
        n_vec++; if (resp_valid1 !== 1'b0) begin n_err++; $error("FAIL rst_resp_valid_l1: observed %0h", resp_valid1); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (req_ready0 !== 1'b1) begin n_err++; $error("FAIL rst_req_ready: observed %0h", req_ready0); end
        n_vec++; if (req_ready1 !== 1'b1) begin n_err++; $error("FAIL rst_req_ready_l1: observed %0h", req_ready1); end

        // Full store then load
        txn(1'b0, 1'b1, 32'h8000_0008, 64'h1122334455667788, 8'hFF, rd, er, lat);
        n_vec++; if (er !== 1'b0) begin n_err++; $error("FAIL st_full_err: observed %0h", er); end
        n_vec++; if (rd !== 64'd0) begin n_err++; $error("FAIL st_full_rdata: observed %0h", rd); end
        n_vec++; if (lat != 2) begin n_err++; $error("FAIL st_full_lat: observed %0d", lat); end
        txn(1'b0, 1'b0, 32'h8000_0008, 64'd0, 8'hFF, rd, er, lat);
        n_vec++; if (rd !== 64'h1122334455667788) begin n_err++; $error("FAIL ld_full_rdata: observed %0h", rd); end
        n_vec++; if (er !== 1'b0) begin n_err++; $error("FAIL ld_full_err: observed %0h", er); end
        n_vec++; if (lat != 2) begin n_err++; $error("FAIL ld_full_lat: observed %0d", lat); end

        // Partial store on lanes 2 and 3
        txn(1'b0, 1'b1, 32'h8000_0008, 64'hFFFFFFFFAABBCCDD, 8'h0C, rd, er, lat);
        n_vec++; if (er !== 1'b0) begin n_err++; $error("FAIL st_part_err: observed %0h", er); end
        txn(1'b0, 1'b0, 32'h8000_000F, 64'd0, 8'h00, rd, er, lat);
        n_vec++; if (rd !== 64'h11223344AABB7788) begin n_err++; $error("FAIL ld_part_rdata: observed %0h", rd); end

        // Range errors
        txn(1'b0, 1'b1, 32'h8000_1FF8, 64'hCAFEF00DCAFEF00D, 8'hFF, rd, er, lat);
        txn(1'b0, 1'b1, 32'h8000_0000, 64'h0BADBEEF00000001, 8'hFF, rd, er, lat);
        txn(1'b0, 1'b0, 32'h7FFF_FFF8, 64'd0, 8'h00, rd, er, lat);
        n_vec++; if (er !== 1'b1) begin n_err++; $error("FAIL ld_below_err: observed %0h", er); end
        n_vec++; if (rd !== 64'd0) begin n_err++; $error("FAIL ld_below_rdata: observed %0h", rd); end
        txn(1'b0, 1'b1, 32'h8000_2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, rd, er, lat);
        n_vec++; if (er !== 1'b1) begin n_err++; $error("FAIL st_above_err: observed %0h", er); end
        n_vec++; if (rd !== 64'd0) begin n_err++; $error("FAIL st_above_rdata: observed %0h", rd); end
        txn(1'b0, 1'b0, 32'h8000_1FF8, 64'd0, 8'h00, rd, er, lat);
        n_vec++; if (rd !== 64'hCAFEF00DCAFEF00D) begin n_err++; $error("FAIL ld_last_rdata: observed %0h", rd); end
        n_vec++; if (er !== 1'b0) begin n_err++; $error("FAIL ld_last_err: observed %0h", er); end
        txn(1'b0, 1'b0, 32'h8000_0000, 64'd0, 8'h00, rd, er, lat);
        n_vec++; if (rd !== 64'h0BADBEEF00000001) begin n_err++; $error("FAIL ld_word0_rdata: observed %0h", rd); end

        // Response backpressure with a request held pending
        req_we = 1'b0; req_addr = 32'h8000_0008; req_wstrb = 8'h00;
        req_valid0 = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (req_ready0 !== 1'b0) begin n_err++; $error("FAIL bp_accepted: observed %0h", req_ready0); end
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (resp_valid0 !== 1'b1) begin n_err++; $error("FAIL bp_first_valid: observed %0h", resp_valid0); end
        n_vec++; if (resp_rdata0 !== 64'h11223344AABB7788) begin n_err++; $error("FAIL bp_first_rdata: observed %0h", resp_rdata0); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++; if (resp_valid0 !== 1'b1) begin n_err++; $error("FAIL bp_hold_valid: observed %0h", resp_valid0); end
            n_vec++; if (resp_rdata0 !== 64'h11223344AABB7788) begin n_err++; $error("FAIL bp_hold_rdata: observed %0h", resp_rdata0); end
            n_vec++; if (resp_err0 !== 1'b0) begin n_err++; $error("FAIL bp_hold_err: observed %0h", resp_err0); end
            n_vec++; if (req_ready0 !== 1'b0) begin n_err++; $error("FAIL bp_hold_ready: observed %0h", req_ready0); end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (resp_valid0 !== 1'b0) begin n_err++; $error("FAIL bp_hs_valid: observed %0h", resp_valid0); end
        n_vec++; if (req_ready0 !== 1'b1) begin n_err++; $error("FAIL bp_hs_ready: observed %0h", req_ready0); end
        @(posedge clk); #1;
        n_vec++; if (req_ready0 !== 1'b0) begin n_err++; $error("FAIL bp_reaccept: observed %0h", req_ready0); end
        req_valid0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (resp_valid0 !== 1'b1) begin n_err++; $error("FAIL bp_second_valid: observed %0h", resp_valid0); end
        @(posedge clk); #1;

        // Reset in the middle of a store's WAIT phase
        txn(1'b0, 1'b1, 32'h8000_0010, 64'h0123456789ABCDEF, 8'hFF, rd, er, lat);
        req_we = 1'b1; req_addr = 32'h8000_0010; req_wdata = 64'hDEAD; req_wstrb = 8'hFF;
        req_valid0 = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (req_ready0 !== 1'b0) begin n_err++; $error("FAIL rstw_accepted: observed %0h", req_ready0); end
        req_valid0 = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_vec++; if (resp_valid0 !== 1'b0) begin n_err++; $error("FAIL rstw_valid: observed %0h", resp_valid0); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_vec++; if (req_ready0 !== 1'b1) begin n_err++; $error("FAIL rstw_ready: observed %0h", req_ready0); end
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 32'h8000_0010, 64'd0, 8'h00, rd, er, lat);
        n_vec++; if (rd !== 64'h0123456789ABCDEF) begin n_err++; $error("FAIL rstw_ld_rdata: observed %0h", rd); end

        // Reset while a response is being held
        req_we = 1'b0; req_addr = 32'h8000_0008; req_valid0 = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (resp_valid0 !== 1'b1) begin n_err++; $error("FAIL rstr_valid_before: observed %0h", resp_valid0); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (resp_valid0 !== 1'b0) begin n_err++; $error("FAIL rstr_valid_async: observed %0h", resp_valid0); end
        n_vec++; if (resp_rdata0 !== 64'd0) begin n_err++; $error("FAIL rstr_rdata_async: observed %0h", resp_rdata0); end
        @(posedge clk); #1 rst = 1'b1;
        #1;
        n_vec++; if (req_ready0 !== 1'b1) begin n_err++; $error("FAIL rstr_ready: observed %0h", req_ready0); end
        @(posedge clk); #1;

        // LATENCY=1 instance with an all-zero strobe store
        txn(1'b1, 1'b1, 32'h8000_0018, 64'hA5A5A5A5A5A5A5A5, 8'hFF, rd, er, lat);
        n_vec++; if (lat != 1) begin n_err++; $error("FAIL l1_st_lat: observed %0d", lat); end
        n_vec++; if (er !== 1'b0) begin n_err++; $error("FAIL l1_st_err: observed %0h", er); end
        txn(1'b1, 1'b1, 32'h8000_0018, 64'h5A5A5A5A5A5A5A5A, 8'h00, rd, er, lat);
        n_vec++; if (lat != 1) begin n_err++; $error("FAIL l1_st0_lat: observed %0d", lat); end
        n_vec++; if (er !== 1'b0) begin n_err++; $error("FAIL l1_st0_err: observed %0h", er); end
        n_vec++; if (rd !== 64'd0) begin n_err++; $error("FAIL l1_st0_rdata: observed %0h", rd); end
        txn(1'b1, 1'b0, 32'h8000_0018, 64'd0, 8'hFF, rd, er, lat);
        n_vec++; if (rd !== 64'hA5A5A5A5A5A5A5A5) begin n_err++; $error("FAIL l1_ld_rdata: observed %0h", rd); end
        n_vec++; if (lat != 1) begin n_err++; $error("FAIL l1_ld_lat: observed %0d", lat); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
